reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Board-level reset controller sitting between the ECP5 PLL and the design.
//  Runs on the raw board clock, not the PLL output. It waits for PLL lock,
//  stretches reset until lock has been stable for a programmable time, then
//  releases peripherals first and the Core a fixed number of cycles later.
//  It re-runs the sequence on PLL lock loss or on a software request, and
//  counts lock-loss events for debug.
// PARAMETERS
//  STRETCH_CYCLES  4194303  cycles lock must stay stable before peripheral release (>=1)
//  PERIPH_LEAD     16       cycles between peripheral release and core release (>=1)
//  LOSS_W          8        width of the saturating lock-loss counter
// PORTS
//  clock            in   1       board reference clock; every flop in this block
//  reset            in   1       synchronous, active-low (board button)
//  pll_lock         in   1       PLL lock, asynchronous to clock
//  sw_reset_req     in   1       single-cycle pulse: re-run the full sequence
//  periph_reset     out  1       active-high reset to UART/LED logic
//  core_reset       out  1       active-high reset to Core
//  ready            out  1       1 only in RUN
//  seq_state        out  2       current state encoding, for debug
//  lock_loss_count  out  LOSS_W  saturating count of lock losses from PERIPH/RUN
// BEHAVIOUR
//  - pll_lock passes through a 2-flop synchroniser (lock_s); both flops reset to 0.
//    All decisions use lock_s only.
//  - States: HOLD=0, STRETCH=1, PERIPH=2, RUN=3.
//  - Outputs are registered together with state; they change on the same edge
//    as seq_state.
//  - reset low: state<=HOLD, periph_reset=1, core_reset=1, ready=0, counter<=0,
//    lock_loss_count<=0, sync flops<=0. Reset wins over every other input.
//  - Output decode: HOLD/STRETCH: periph_reset=1, core_reset=1.
//    PERIPH: periph_reset=0, core_reset=1. RUN: both 0, ready=1.
//  - HOLD -> STRETCH when lock_s=1; counter loaded with STRETCH_CYCLES-1.
//  - STRETCH lasts exactly STRETCH_CYCLES cycles with lock_s=1.
//    At counter=0 -> PERIPH, counter loaded with PERIPH_LEAD-1.
//  - PERIPH lasts exactly PERIPH_LEAD cycles, then -> RUN. RUN holds indefinitely.
//  - lock_s=0 in STRETCH/PERIPH/RUN -> HOLD on the next edge, resets reasserted.
//    lock_loss_count += 1 (saturating at 2^LOSS_W-1) only when leaving PERIPH or RUN.
//  - sw_reset_req=1 in RUN -> HOLD. It is ignored in the other states and is not queued.
//  - Priority: reset > lock loss > sw_reset_req > counter expiry.
//  - Counter width is $clog2(max(STRETCH_CYCLES,PERIPH_LEAD)+1). It never wraps:
//    it is only decremented while nonzero and is reloaded on every state entry.
//  - Lock glitch of any length >=1 synced cycle restarts the stretch from the full
//    count. There is no partial credit.
// STRUCTURE
//  - Package reset_seq_pkg: typedef enum logic [1:0] seq_state_t {HOLD,STRETCH,
//    PERIPH,RUN}.
//  - Sub-module sync_2ff (generic 1-bit 2-flop synchroniser, reset value 0).
//    It is used for pll_lock and is reusable for io_rx.
//  - Top level instantiates reset_sequencer in place of the ad-hoc counter.
//    core_reset drives Core.reset.
// TESTING (STRETCH_CYCLES=8, PERIPH_LEAD=4, LOSS_W=2; edge 0 = first edge with reset=1)
//  1 Power-up, pll_lock=1 throughout.
//    -> seq_state=STRETCH at edge 2; periph_reset falls at edge 10;
//       core_reset falls and ready rises at edge 14.
//  2 pll_lock=0 for 3 cycles at edge 20 (in RUN).
//    -> HOLD with both resets high within 3 edges; lock_loss_count=1.
//       The full sequence replays: 12 edges from lock_s rising to core release.
//  3 Single-cycle lock glitch in STRETCH at edge 6.
//    -> back to HOLD, lock_loss_count stays 0. The stretch restarts and runs the
//       full 8 cycles.
//  4 Four lock losses from RUN -> lock_loss_count saturates at 3 and stays 3.
//  5 sw_reset_req pulse in STRETCH -> ignored, release at edge 10.
//    Pulse in RUN -> HOLD next edge, core_reset=1, count unchanged.
//  6 reset driven low in PERIPH, and also on the same edge as sw_reset_req.
//    -> all outputs reach reset values on the next edge; counter 0; lock_loss_count 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types for the board reset sequencer: the sequencer state encoding,
// which is also exported on seq_state for debug.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    PERIPH  = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with a synchronous active-low reset to 0.
// Used for pll_lock and suitable for io_rx.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: waits for a stable PLL lock, releases peripherals,
// then the core PERIPH_LEAD cycles later; restarts on lock loss or sw request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES = 4194303,
  parameter int unsigned PERIPH_LEAD    = 16,
  parameter int unsigned LOSS_W         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_lock,
  input  logic              sw_reset_req,
  output logic              periph_reset,
  output logic              core_reset,
  output logic              ready,
  output logic [1:0]        seq_state,
  output logic [LOSS_W-1:0] lock_loss_count
);

  localparam int unsigned CNT_W = $clog2(max_u(STRETCH_CYCLES, PERIPH_LEAD) + 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LOAD  = CNT_W'(PERIPH_LEAD - 1);

  logic lock_s;

  seq_state_t        state_reg,  state_next;
  logic [CNT_W-1:0]  cnt_reg,    cnt_next;
  logic [LOSS_W-1:0] loss_reg,   loss_next;
  logic              periph_reg, periph_next;
  logic              core_reg,   core_next;
  logic              ready_reg,  ready_next;

  sync_2ff u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= HOLD;
      cnt_reg    <= '0;
      loss_reg   <= '0;
      periph_reg <= 1'b1;
      core_reg   <= 1'b1;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      loss_reg   <= loss_next;
      periph_reg <= periph_next;
      core_reg   <= core_next;
      ready_reg  <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loss_next  = loss_reg;

    unique case (state_reg)
      HOLD: begin
        if (lock_s) begin
          state_next = STRETCH;
          cnt_next   = STRETCH_LOAD;
        end
      end
      STRETCH: begin
        // A glitch here is not counted: the PLL never delivered a usable clock yet.
        if (!lock_s) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = PERIPH;
          cnt_next   = PERIPH_LOAD;
        end else begin
          cnt_next   = cnt_reg - CNT_W'(1);
        end
      end
      PERIPH: begin
        if (!lock_s) begin
          state_next = HOLD;
          cnt_next   = '0;
          loss_next  = (&loss_reg) ? loss_reg : loss_reg + LOSS_W'(1);
        end else if (cnt_reg == '0) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg - CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = HOLD;
          cnt_next   = '0;
          loss_next  = (&loss_reg) ? loss_reg : loss_reg + LOSS_W'(1);
        end else if (sw_reset_req) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = HOLD;
        cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    periph_next = (state_next == HOLD) || (state_next == STRETCH);
    core_next   = (state_next != RUN);
    ready_next  = (state_next == RUN);
  end

  assign periph_reset    = periph_reg;
  assign core_reset      = core_reg;
  assign ready           = ready_reg;
  assign seq_state       = state_reg;
  assign lock_loss_count = loss_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with short stretch/lead times:
// directed scenarios plus a per-cycle behavioural model comparison.
module tb_reset_sequencer;

  localparam int S = 8;
  localparam int P = 4;
  localparam int W = 2;
  localparam int LOSS_MAX = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         pll_lock;
  logic         sw_reset_req;
  logic         periph_reset;
  logic         core_reset;
  logic         ready;
  logic [1:0]   seq_state;
  logic [W-1:0] lock_loss_count;

  int tests = 0;
  int fails = 0;
  int e     = 0;

  reset_sequencer #(
    .STRETCH_CYCLES (S),
    .PERIPH_LEAD    (P),
    .LOSS_W         (W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .sw_reset_req    (sw_reset_req),
    .periph_reset    (periph_reset),
    .core_reset      (core_reset),
    .ready           (ready),
    .seq_state       (seq_state),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s edge=%0d got=%0d expected=%0d", name, e, got, exp);
    end
  endtask

  // Model: mk = edges elapsed since leaving HOLD (-1 while held); the lock
  // seen by the decision is pll_lock delayed by two sampled edges.
  int mk = -1, ms1 = 0, ms2 = 0, mloss = 0;
  bit model_valid = 1'b0;

  always @(posedge clock) begin : model
    int ls;
    ls = ms2;
    if (!reset) begin
      mk = -1; ms1 = 0; ms2 = 0; mloss = 0;
    end else begin
      ms2 = ms1;
      ms1 = int'(pll_lock);
      if (ls == 0) begin
        if (mk >= S) mloss = (mloss < LOSS_MAX) ? mloss + 1 : LOSS_MAX;
        mk = -1;
      end else if (sw_reset_req && mk >= S + P) begin
        mk = -1;
      end else if (mk < S + P) begin
        mk++;
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge clock) begin
    if (model_valid) begin
      chk("m_state",  int'(seq_state),
          (mk < 0) ? 0 : (mk < S) ? 1 : (mk < S + P) ? 2 : 3);
      chk("m_periph", int'(periph_reset), int'(mk < S));
      chk("m_core",   int'(core_reset),   int'(mk < S + P));
      chk("m_ready",  int'(ready),        int'(mk >= S + P));
      chk("m_loss",   int'(lock_loss_count), mloss);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic to_edge(input int n);
    while (e < n) cyc();
  endtask

  // Leaves the bench #1 after an edge such that the next edge is edge 0.
  task automatic restart();
    reset = 1'b0; pll_lock = 1'b1; sw_reset_req = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    e = -1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 60) begin cyc(); n++; end
    chk("ready_timeout", int'(ready), 1);
  endtask

  initial begin
    reset = 1'b0; pll_lock = 1'b1; sw_reset_req = 1'b0;

    // 1: power-up and lock loss replay
    restart();
    to_edge(1);  chk("s1_hold_e1",    int'(seq_state), 0);
    chk("s1_rst_periph", int'(periph_reset), 1);
    to_edge(2);  chk("s1_stretch_e2", int'(seq_state), 1);
    to_edge(9);  chk("s1_periph_e9",  int'(periph_reset), 1);
    to_edge(10); chk("s1_periph_e10", int'(periph_reset), 0);
    to_edge(13); chk("s1_core_e13",   int'(core_reset), 1);
    to_edge(14); chk("s1_core_e14",   int'(core_reset), 0);
    chk("s1_ready_e14", int'(ready), 1);
    to_edge(19); pll_lock = 1'b0;
    to_edge(22); pll_lock = 1'b1;
    chk("s2_hold",   int'(seq_state), 0);
    chk("s2_core",   int'(core_reset), 1);
    chk("s2_loss",   int'(lock_loss_count), 1);
    to_edge(36); chk("s2_ready_e36", int'(ready), 0);
    to_edge(37); chk("s2_ready_e37", int'(ready), 1);

    // 3: one-cycle glitch during STRETCH
    restart();
    to_edge(5); pll_lock = 1'b0;
    to_edge(6); pll_lock = 1'b1;
    to_edge(7);  chk("s3_still_stretch", int'(seq_state), 1);
    to_edge(8);  chk("s3_hold",   int'(seq_state), 0);
    chk("s3_loss0", int'(lock_loss_count), 0);
    to_edge(16); chk("s3_stretch_e16", int'(seq_state), 1);
    to_edge(17); chk("s3_periph_e17",  int'(seq_state), 2);
    to_edge(21); chk("s3_run_e21",     int'(seq_state), 3);

    // 4: saturation of the loss counter
    for (int i = 0; i < 4; i++) begin
      pll_lock = 1'b0; cyc(); pll_lock = 1'b1; cyc(); cyc();
      chk("s4_hold", int'(seq_state), 0);
      chk("s4_loss", int'(lock_loss_count), (i + 1 < 3) ? i + 1 : 3);
      wait_ready();
    end

    // 5: sw_reset_req ignored in STRETCH, honoured in RUN
    restart();
    to_edge(4);  sw_reset_req = 1'b1;
    to_edge(5);  sw_reset_req = 1'b0;
    to_edge(10); chk("s5_periph_e10", int'(seq_state), 2);
    to_edge(14); chk("s5_ready_e14",  int'(ready), 1);
    to_edge(20); sw_reset_req = 1'b1;
    to_edge(21); sw_reset_req = 1'b0;
    chk("s5_hold", int'(seq_state), 0);
    chk("s5_core", int'(core_reset), 1);
    chk("s5_loss", int'(lock_loss_count), 0);
    to_edge(22); chk("s5_restretch", int'(seq_state), 1);

    // 6b: reset together with sw_reset_req after a counted loss
    restart();
    wait_ready();
    pll_lock = 1'b0; cyc(); pll_lock = 1'b1; cyc(); cyc();
    chk("s6_loss1", int'(lock_loss_count), 1);
    wait_ready();
    reset = 1'b0; sw_reset_req = 1'b1; cyc();
    chk("s6b_state", int'(seq_state), 0);
    chk("s6b_ready", int'(ready), 0);
    chk("s6b_core",  int'(core_reset), 1);
    chk("s6b_loss",  int'(lock_loss_count), 0);
    reset = 1'b1; sw_reset_req = 1'b0; e = -1;

    // 6a: reset in PERIPH
    to_edge(11); chk("s6a_in_periph", int'(seq_state), 2);
    reset = 1'b0; cyc();
    chk("s6a_state",  int'(seq_state), 0);
    chk("s6a_periph", int'(periph_reset), 1);
    chk("s6a_core",   int'(core_reset), 1);
    reset = 1'b1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
